multicyc_ctrl: RTL and testbench

- Dual-lane scheduler in front of the single multicycle HI/LO unit.
- Accepts multicycle requests (MULT/MULTU/DIV/DIVU/MTHI/MTLO and optional MADD/MSUB family) from issue lanes 0 and 1, serialises them in program order (lane 0 older) and stalls each lane until its op completes.
- Owns the architectural HI/LO register, supplies it as operand to every issued op and commits results.
- Handles pipeline flush, including draining an op already in flight in the non-cancellable unit.

---
 rtl/multicyc_ctrl.sv | 82 ++++++++
 tb/tb_multicyc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicyc_ctrl.sv
// multicyc_ctrl: dual-lane in-order scheduler and HI/LO owner for the multicycle unit.
// Define MULTICYC_CTRL_FWD_EN to forward the committing result to readers and chain lane 1 a cycle early.
module multicyc_ctrl #(
    parameter int          OP_W     = 8,
    parameter logic [63:0] HILO_RST = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           lane_req_valid,
    input  logic [1:0][OP_W-1:0] lane_op,
    input  logic [1:0][31:0]     lane_reg0,
    input  logic [1:0][31:0]     lane_reg1,
    output logic [1:0]           lane_stall,
    output logic [1:0]           lane_done,
    input  logic                 flush,
    output logic                 unit_req_valid,
    output logic [OP_W-1:0]      unit_req_op,
    output logic [31:0]          unit_req_reg0,
    output logic [31:0]          unit_req_reg1,
    output logic [63:0]          unit_req_hilo,
    input  logic                 unit_ready,
    input  logic                 unit_valid,
    input  logic [63:0]          unit_hilo,
    output logic [63:0]          hilo_rdata,
    output logic                 busy
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DRAIN = 2'd3;
    logic [1:0]      state, state_nx;
    logic [63:0]     hilo;
    logic            sel, pick, pick_lane, commit, chain, stall0;
    logic [OP_W-1:0] op_q;
    logic [31:0]     reg0_q, reg1_q;
    assign commit = (state == WAIT) & unit_valid & ~flush;
`ifdef MULTICYC_CTRL_FWD_EN
    assign chain      = commit & ~sel & lane_req_valid[1];
    assign hilo_rdata = commit ? unit_hilo : hilo;
`else
    assign chain      = 1'b0;
    assign hilo_rdata = hilo;
`endif
    // The done cycle blocks selection so the retiring lane's still-high request is not re-issued.
    assign pick      = ((state == IDLE) & ~flush & (lane_done == 2'b00) & (|lane_req_valid)) | chain;
    assign pick_lane = chain | ~lane_req_valid[0];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pick ? ISSUE : IDLE;
            ISSUE:   state_nx = flush ? IDLE : (unit_ready ? WAIT : ISSUE);
            WAIT:    state_nx = unit_valid ? (pick ? ISSUE : IDLE) : (flush ? DRAIN : WAIT);
            default: state_nx = unit_valid ? IDLE : DRAIN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hilo      <= HILO_RST;
            sel       <= 1'b0;
            op_q      <= '0;
            reg0_q    <= '0;
            reg1_q    <= '0;
            lane_done <= 2'b00;
        end else begin
            state     <= state_nx;
            lane_done <= commit ? (sel ? 2'b10 : 2'b01) : 2'b00;
            if (commit) hilo <= unit_hilo;
            if (pick) begin
                sel    <= pick_lane;
                op_q   <= lane_op[pick_lane];
                reg0_q <= lane_reg0[pick_lane];
                reg1_q <= lane_reg1[pick_lane];
            end
        end
    end
    assign unit_req_valid = (state == ISSUE) & unit_ready & ~flush;
    assign unit_req_op    = (state == ISSUE) ? op_q : '0;
    assign unit_req_hilo  = (state == ISSUE) ? hilo : '0;
    assign unit_req_reg0  = reg0_q;
    assign unit_req_reg1  = reg1_q;
    assign stall0         = lane_req_valid[0] & ~lane_done[0];
    assign lane_stall     = {(lane_req_valid[1] & ~lane_done[1]) | stall0, stall0};
    assign busy           = state != IDLE;
endmodule

// File: tb/tb_multicyc_ctrl.sv
// tb_multicyc_ctrl: directed bench for multicyc_ctrl with a latency model of the HI/LO unit.
module tb_multicyc_ctrl;
    localparam logic [7:0] MULT = 8'd1, MULTU = 8'd2, DIV = 8'd3, DIVU = 8'd4, MTHI = 8'd5, MTLO = 8'd6;
    logic            clk = 0, rst = 1, flush = 0, unit_ready = 1, unit_valid = 0;
    logic [1:0]      lane_req_valid = 0, lane_stall, lane_done;
    logic [1:0][7:0] lane_op = '0;
    logic [1:0][31:0] lane_reg0 = '0, lane_reg1 = '0;
    logic            unit_req_valid, busy;
    logic [7:0]      unit_req_op;
    logic [31:0]     unit_req_reg0, unit_req_reg1;
    logic [63:0]     unit_req_hilo, unit_hilo = 0, hilo_rdata, res;
    int tests = 0, fails = 0, cyc = 0, cnt = 0, issues = 0, done0 = 0, done1 = 0, uv_cyc = 0, done_cyc = 0;
    int n0, d0, d1;
    logic [7:0]  iss_op [0:63];
    logic [63:0] iss_hilo [0:63];

    multicyc_ctrl #(.OP_W(8), .HILO_RST(64'h0)) dut (
        .clk(clk), .rst(rst), .lane_req_valid(lane_req_valid), .lane_op(lane_op),
        .lane_reg0(lane_reg0), .lane_reg1(lane_reg1), .lane_stall(lane_stall), .lane_done(lane_done),
        .flush(flush), .unit_req_valid(unit_req_valid), .unit_req_op(unit_req_op),
        .unit_req_reg0(unit_req_reg0), .unit_req_reg1(unit_req_reg1), .unit_req_hilo(unit_req_hilo),
        .unit_ready(unit_ready), .unit_valid(unit_valid), .unit_hilo(unit_hilo),
        .hilo_rdata(hilo_rdata), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] calc(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] h);
        longint sa, sb;
        int q, r;
        sa = $signed(a);
        sb = $signed(b);
        q = (b == 0) ? 0 : int'(a) / int'(b);
        r = (b == 0) ? 0 : int'(a) % int'(b);
        case (op)
            MULT:    return sa * sb;
            MULTU:   return 64'(a) * 64'(b);
            DIV:     return {r, q};
            DIVU:    return (b == 0) ? 64'h0 : {a % b, a / b};
            MTHI:    return {a, h[31:0]};
            MTLO:    return {h[63:32], a};
            default: return h;
        endcase
    endfunction

    // Unit model: MULT-class 2 cycles, DIV-class 36 cycles, one op at a time.
    always @(negedge clk) begin
        unit_valid = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                unit_valid = 1;
                unit_hilo = res;
                uv_cyc = cyc;
            end
        end
        if (unit_req_valid) begin
            iss_op[issues] = unit_req_op;
            iss_hilo[issues] = unit_req_hilo;
            issues++;
            cnt = (unit_req_op == DIV || unit_req_op == DIVU) ? 36 : 2;
            res = calc(unit_req_op, unit_req_reg0, unit_req_reg1, unit_req_hilo);
        end
        if (lane_done[0]) done0++;
        if (lane_done[1]) done1++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        lane_req_valid = 0;
        flush = 0;
        unit_ready = 1;
        repeat (2) step();
        rst = 0;
    endtask

    task automatic req(input int l, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        lane_op[l] = op;
        lane_reg0[l] = a;
        lane_reg1[l] = b;
        lane_req_valid[l] = 1;
    endtask

    task automatic wait_done(input int l);
        for (int n = 0; n < 200; n++) begin
            step();
            if (lane_done[l]) break;
        end
        check("done_seen", {63'b0, lane_done[l]}, 64'd1);
        lane_req_valid[l] = 0;
        done_cyc = cyc;
    endtask

    task automatic wait_uv();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (unit_valid) break;
        end
        check("uv_seen", {63'b0, unit_valid}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_hilo", hilo_rdata, 64'h0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_stall", {62'b0, lane_stall}, 64'd0);
        check("rst_done", {62'b0, lane_done}, 64'd0);
        check("rst_uvalid", {63'b0, unit_req_valid}, 64'd0);
        check("rst_uop", {56'b0, unit_req_op}, 64'd0);

        // Single signed MULT on lane 0.
        n0 = issues;
        req(0, MULT, 32'd3, 32'hFFFFFFFE);
        #1;
        check("mult_stall0", {63'b0, lane_stall[0]}, 64'd1);
        check("mult_stall1_follow", {63'b0, lane_stall[1]}, 64'd1);
        step();
        check("mult_issue_pulse", {63'b0, unit_req_valid}, 64'd1);
        check("mult_issue_op", {56'b0, unit_req_op}, {56'b0, MULT});
        step();
        check("mult_pulse_once", {63'b0, unit_req_valid}, 64'd0);
        check("mult_wait_stall", {63'b0, lane_stall[0]}, 64'd1);
        wait_done(0);
        check("mult_done_lag", 64'(done_cyc - uv_cyc), 64'd1);
        check("mult_hilo", hilo_rdata, 64'hFFFFFFFF_FFFFFFFA);
        check("mult_stall_rel", {63'b0, lane_stall[0]}, 64'd0);
        check("mult_issues", 64'(issues - n0), 64'd1);
        step();
        check("mult_done_1cyc", {62'b0, lane_done}, 64'd0);
        check("mult_idle", {63'b0, busy}, 64'd0);

        // Dual issue: lane 0 older, lane 1 sees lane 0's result.
        do_reset();
        n0 = issues;
        req(0, MTLO, 32'h1234, 32'h0);
        req(1, MTHI, 32'hABCD, 32'h0);
        wait_done(0);
        check("dual_l1_stalled", {63'b0, lane_stall[1]}, 64'd1);
        wait_done(1);
        check("dual_first_op", {56'b0, iss_op[n0]}, {56'b0, MTLO});
        check("dual_second_op", {56'b0, iss_op[n0+1]}, {56'b0, MTHI});
        check("dual_l1_hilo", iss_hilo[n0+1], 64'h0000_0000_0000_1234);
        check("dual_final", hilo_rdata, 64'h0000ABCD_00001234);
        check("dual_issues", 64'(issues - n0), 64'd2);

        // Backpressure: no pulse while the unit is not ready.
        do_reset();
        n0 = issues;
        unit_ready = 0;
        req(0, MULT, 32'd2, 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_no_pulse", {63'b0, unit_req_valid}, 64'd0);
            check("bp_op", {56'b0, unit_req_op}, {56'b0, MULT});
        end
        check("bp_busy", {63'b0, busy}, 64'd1);
        unit_ready = 1;
        #1;
        check("bp_pulse", {63'b0, unit_req_valid}, 64'd1);
        wait_done(0);
        check("bp_issues", 64'(issues - n0), 64'd1);
        check("bp_hilo", hilo_rdata, 64'd6);

        // Flush while a DIV is in flight: drain, discard.
        do_reset();
        d0 = done0;
        req(0, DIV, 32'd100, 32'd7);
        step();
        check("fl_div_issue", {63'b0, unit_req_valid}, 64'd1);
        repeat (10) step();
        flush = 1;
        lane_req_valid = 0;
        step();
        flush = 0;
        check("fl_drain_busy", {63'b0, busy}, 64'd1);
        wait_uv();
        check("fl_busy_at_uv", {63'b0, busy}, 64'd1);
        step();
        check("fl_busy_drop", {63'b0, busy}, 64'd0);
        step();
        check("fl_hilo", hilo_rdata, 64'h0);
        check("fl_no_done", 64'(done0 - d0), 64'd0);

        // Flush coincident with unit_valid.
        do_reset();
        req(0, MTLO, 32'd1, 32'd0);
        wait_done(0);
        step();
        d0 = done0;
        req(0, MULT, 32'd5, 32'd5);
        wait_uv();
        flush = 1;
        lane_req_valid = 0;
        step();
        flush = 0;
        check("fc_idle", {63'b0, busy}, 64'd0);
        check("fc_done0", {62'b0, lane_done}, 64'd0);
        step();
        check("fc_hilo", hilo_rdata, 64'h1);
        check("fc_no_done", 64'(done0 - d0), 64'd0);

        // Reset while WAIT on a DIV, then the late result arrives.
        d0 = done0;
        d1 = done1;
        req(0, DIV, 32'd100, 32'd7);
        repeat (6) step();
        check("rw_busy", {63'b0, busy}, 64'd1);
        do_reset();
        check("rw_rst_busy", {63'b0, busy}, 64'd0);
        check("rw_rst_hilo", hilo_rdata, 64'h0);
        wait_uv();
        step();
        check("rw_late_busy", {63'b0, busy}, 64'd0);
        step();
        check("rw_late_hilo", hilo_rdata, 64'h0);
        check("rw_no_done", 64'((done0 - d0) + (done1 - d1)), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
